pipe_stage_bank: RTL and testbench
==================================

Name: pipe_stage_bank

Overview:
- Parametrised pipeline register chain replacing per-signal hand-instantiated IF/RF/EX/MEM/WB registers.
- Carries a WIDTH-bit payload plus a valid bit through DEPTH stages.
- Per-stage stall (hold) with automatic backward stall propagation and bubble insertion; per-stage flush for branch/jump squash.
- Exposes every stage's contents for forwarding/hazard logic.

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 4, number of stages (2..8); stage 0 is nearest the input.
- RESET_VAL, 0, payload value loaded on reset (WIDTH bits).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  WIDTH  payload entering stage 0.
- in_valid  in  1  in_data is a real instruction.
- stall  in  DEPTH  stall[k]=1 requests stage k hold its contents.
- flush  in  DEPTH  flush[k]=1 invalidates stage k at the next edge.
- in_ready  out  1  stage 0 will accept in_data this cycle.
- stage_data  out  DEPTH*WIDTH  stage k payload at bits [k*WIDTH +: WIDTH].
- stage_valid  out  DEPTH  stage k valid bit.
- out_data  out  WIDTH  equals stage DEPTH-1 payload.
- out_valid  out  1  equals stage_valid[DEPTH-1].
- bubble_cnt  out  CNT_W  saturating count of cycles in which at least one bubble was inserted.

Behaviour:
- Reset (reset=0, asynchronous): all stage payloads = RESET_VAL, all valid = 0, bubble_cnt = 0.
  - Reset takes effect immediately, including mid-stall or mid-flush; nothing survives.
  - The first edge after release behaves normally.
- Hold, combinational:
  - hold[DEPTH-1] = stall[DEPTH-1].
  - hold[k] = stall[k] | hold[k+1] for k < DEPTH-1.
  - A stalled stage freezes every stage upstream of it.
- in_ready = ~hold[0], combinational; in_data/in_valid are ignored when in_ready=0.
- Per-edge update for stage k, in priority order:
  1. flush[k]=1: valid[k] <= 0. Payload <= the value it would otherwise take (rules 2-4). Flush beats hold and load.
  2. hold[k]=1: payload and valid unchanged.
  3. k>0 and hold[k-1]=1 (upstream frozen, this stage moving): bubble inserted. valid[k] <= 0, payload unchanged.
  4. Otherwise load: stage 0 takes in_data/in_valid; stage k>0 takes stage k-1 payload/valid.
- Latency: an unstalled, unflushed item appears at out_data exactly DEPTH edges after acceptance.
- bubble_cnt: increments by 1 on any edge where rule 3 fires for any k and no flush applies at that k. Saturates at all-ones.
- No combinational path from stall/flush to stage_data, stage_valid, out_data or out_valid. in_ready is combinational from stall only.
- stall/flush bits for all stages are independent; simultaneous assertion on any mix of stages is legal and obeys the priority above.

Test Plan:
- DEPTH=4, WIDTH=32, feed 0x11,0x22,0x33,0x44,0x55 valid on consecutive edges, no stall -> out_data=0x11 with out_valid=1 on edge 4; then 0x22..0x55 on edges 5-8; bubble_cnt=0.
- After stages 0..3 hold 0x44,0x33,0x22,0x11, assert stall=4'b0010 for 2 cycles -> in_ready=0; stages 0,1 hold 0x44,0x33; stage 2 valid=0 after first edge; out shows 0x22 then bubble; bubble_cnt=2.
- Full pipe, assert flush=4'b0011 for 1 cycle with in_data=0x66 valid -> next edge: stage0 valid=0, stage1 valid=0, stage2=0x33 valid, stage3=0x22 valid.
- stall=4'b0001 and flush=4'b0001 together with stage0=0x77 valid -> stage0 payload stays 0x77, valid=0; in_ready=0 during the cycle.
- Mid-stream, drive reset=0 between edges -> all stage_valid=0, payloads=0, bubble_cnt=0 immediately without a clock edge; after release, 0xAA enters and exits 4 edges later.
- Force bubble_cnt to all-ones (CNT_W=4, 16 bubble cycles, then one more) -> bubble_cnt stays 4'hF.

Source files
------------

// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: parametrised payload/valid pipeline register chain
// with stall back-propagation, bubble insertion and per-stage flush.
module pipe_stage_bank #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic                   in_ready,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       bubble_cnt
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] bub;
  logic             bub_hit;

  // a stage holds if it or anything downstream stalls
  always_comb begin
    hold = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic h;
      h = 1'b0;
      for (int j = k; j < DEPTH; j++)
        h = h | stall[j];
      hold[k] = h;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    bub     = '0;
    if (!hold[0]) begin
      data_d[0]  = in_data;
      valid_d[0] = in_valid;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (!hold[k]) begin
        if (hold[k-1]) begin
          valid_d[k] = 1'b0;
          bub[k]     = 1'b1;
        end else begin
          data_d[k]  = data_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end
    // flush squashes the valid bit only; payload follows normal rules
    valid_d = valid_d & ~flush;
  end

  assign bub_hit = |(bub & ~flush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++)
        data_q[k] <= RESET_VAL;
      valid_q    <= '0;
      bubble_cnt <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      if (bub_hit && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign stage_valid = valid_q;
  assign out_data    = data_q[DEPTH-1];
  assign out_valid   = valid_q[DEPTH-1];
  assign in_ready    = ~hold[0];

endmodule

// File: tb/tb_pipe_stage_bank.sv
// tb_pipe_stage_bank: directed stimulus with an output-stream scoreboard
// plus direct checks of stage contents, in_ready and bubble_cnt.
module tb_pipe_stage_bank;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic [D-1:0]   stall = '0;
  logic [D-1:0]   flush = '0;
  logic           in_ready;
  logic [D*W-1:0] stage_data;
  logic [D-1:0]   stage_valid;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [CW-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_bank #(
    .WIDTH(W), .DEPTH(D), .RESET_VAL('0), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .in_ready   (in_ready),
    .stage_data (stage_data),
    .stage_valid(stage_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .bubble_cnt (bubble_cnt)
  );

  function automatic logic [W-1:0] sd(input int k);
    return stage_data[k*W +: W];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [W-1:0] d, input bit exits);
    in_data  = d;
    in_valid = 1'b1;
    if (exits) exp_q.push_back(d);
    step();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL sb_out: got %h expected %h", out_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    chk("rst_valid", W'(stage_valid), '0);
    chk("rst_data", stage_data[W-1:0] | sd(3), '0);
    chk("rst_cnt", W'(bubble_cnt), '0);
    rst_n = 1'b1;

    // streaming, no stall
    send(32'h11, 1);
    send(32'h22, 1);
    send(32'h33, 1);
    chk("lat_early", W'(out_valid), 0);
    send(32'h44, 1);
    chk("lat_valid", W'(out_valid), 1);
    chk("lat_data", out_data, 32'h11);
    send(32'h55, 1);
    idle(5);
    chk("p1_cnt", W'(bubble_cnt), 0);

    // stall stage 1 for two cycles
    send(32'h11, 1);
    send(32'h22, 1);
    send(32'h33, 1);
    send(32'h44, 1);
    stall = 4'b0010;
    in_data = 32'h55;
    in_valid = 1'b1;
    #1;
    chk("st_ready", W'(in_ready), 0);
    step();
    chk("st_v2", W'(stage_valid[2]), 0);
    chk("st_v01", W'(stage_valid[1:0]), 2'b11);
    chk("st_s0", sd(0), 32'h44);
    chk("st_s1", sd(1), 32'h33);
    step();
    chk("st_cnt", W'(bubble_cnt), 2);
    chk("st_outv", W'(out_valid), 0);
    stall = '0;
    idle(5);

    // flush stages 0 and 1
    send(32'h11, 1);
    send(32'h22, 1);
    send(32'h33, 1);
    send(32'h44, 0);
    flush = 4'b0011;
    in_data = 32'h66;
    in_valid = 1'b1;
    step();
    chk("fl_valid", W'(stage_valid), 4'b1100);
    chk("fl_s0", sd(0), 32'h66);
    chk("fl_s1", sd(1), 32'h44);
    chk("fl_s2", sd(2), 32'h33);
    chk("fl_s3", sd(3), 32'h22);
    flush = '0;
    idle(5);

    // stall and flush on stage 0 together
    send(32'h77, 0);
    stall = 4'b0001;
    flush = 4'b0001;
    in_data = 32'h88;
    #1;
    chk("sf_ready", W'(in_ready), 0);
    step();
    chk("sf_s0", sd(0), 32'h77);
    chk("sf_v0", W'(stage_valid[0]), 0);
    chk("sf_cnt", W'(bubble_cnt), 3);
    stall = '0;
    flush = '0;
    idle(5);

    // asynchronous reset mid-stream
    send(32'hA1, 0);
    send(32'hA2, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", W'(stage_valid), '0);
    chk("ar_s0", sd(0), '0);
    chk("ar_s1", sd(1), '0);
    chk("ar_cnt", W'(bubble_cnt), '0);
    #1 rst_n = 1'b1;
    send(32'hAA, 1);
    idle(2);
    chk("ar_early", W'(out_valid), 0);
    step();
    chk("ar_outv", W'(out_valid), 1);
    chk("ar_out", out_data, 32'hAA);
    step();

    // flushed bubble is not counted, then saturation
    stall = 4'b0001;
    flush = 4'b0010;
    step();
    chk("fb_cnt", W'(bubble_cnt), 0);
    flush = '0;
    repeat (14) step();
    chk("sat_14", W'(bubble_cnt), 4'hE);
    repeat (2) step();
    chk("sat_16", W'(bubble_cnt), 4'hF);
    step();
    chk("sat_17", W'(bubble_cnt), 4'hF);
    stall = '0;
    idle(2);

    chk("sb_empty", W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
